// File: rtl/dca_lsu_inst_arbiter_pkg.sv
// dca_lsu_inst_arbiter_pkg: shared widths and defaults for the LSU instruction arbiter
`ifndef BW_DCA_MATRIX_LSU_INST
`define BW_DCA_MATRIX_LSU_INST 32
`endif
package dca_lsu_inst_arbiter_pkg;
  localparam int DCA_LSU_INST_W = `BW_DCA_MATRIX_LSU_INST;
  localparam int DCA_LSU_ARB_ORDER_DEPTH = 4;
  function automatic int bw_dca_lsu_arb_id(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction
endpackage

// File: rtl/dca_lsu_inst_arbiter_if.sv
// dca_lsu_inst_arbiter_if: requester and LSU handshake bundle around the arbiter
interface dca_lsu_inst_arbiter_if
  import dca_lsu_inst_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int BW_INST = DCA_LSU_INST_W
);
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ*BW_INST-1:0] req_inst;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ-1:0]         req_done;
  logic                       lsu_inst_valid;
  logic                       lsu_inst_ready;
  logic [BW_INST-1:0]         lsu_inst;
  logic                       lsu_done;
  modport slave (
    input  req_valid, req_inst, lsu_inst_ready, lsu_done,
    output req_ready, req_done, lsu_inst_valid, lsu_inst
  );
  modport master (
    output req_valid, req_inst, lsu_inst_ready, lsu_done,
    input  req_ready, req_done, lsu_inst_valid, lsu_inst
  );
endinterface

// File: rtl/dca_grant_order_fifo.sv
// dca_grant_order_fifo: in-order record of granted requester IDs awaiting LSU completion
module dca_grant_order_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             data_i,
  output logic [W-1:0]             data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;
  assign full_o  = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  always_comb begin
    wr_d  = clear_i ? '0 : do_push ? wr_q + PW'(1) : wr_q;
    rd_d  = clear_i ? '0 : do_pop ? rd_q + PW'(1) : rd_q;
    cnt_d = clear_i ? '0 : cnt_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end
endmodule

// File: rtl/dca_lsu_inst_arbiter.sv
// dca_lsu_inst_arbiter: round-robin share of one matrix LSU instruction port with
// in-order completion routing back to the issuing sequencer
module dca_lsu_inst_arbiter
  import dca_lsu_inst_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int BW_INST     = DCA_LSU_INST_W,
  parameter int ORDER_DEPTH = DCA_LSU_ARB_ORDER_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   enable,
  dca_lsu_inst_arbiter_if.slave  bus,
  output logic                   busy,
  output logic                   err_spurious_done
);
  localparam int ID_W = bw_dca_lsu_arb_id(NUM_REQ);
  localparam int CW   = $clog2(ORDER_DEPTH) + 1;
  logic [BW_INST-1:0] inst_arr [NUM_REQ];
  logic [ID_W-1:0]    last_q, last_d, gnt_id, idx, head_id;
  logic [BW_INST-1:0] inst_q, inst_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               valid_q, valid_d, err_q, err_d;
  logic               found, accept, pop, full, empty;
  logic [CW-1:0]      count;
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign inst_arr[g] = bus.req_inst[g*BW_INST +: BW_INST];
  end
  // Walk forward from the slot after the last winner, wrapping at NUM_REQ
  always_comb begin
    found  = 1'b0;
    gnt_id = '0;
    idx    = last_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (idx == ID_W'(NUM_REQ - 1)) ? '0 : idx + ID_W'(1);
      if (!found && bus.req_valid[idx]) begin
        found  = 1'b1;
        gnt_id = idx;
      end
    end
  end
  assign accept = ~clear & enable & (~valid_q | bus.lsu_inst_ready) & ~full & found;
  assign pop    = ~clear & bus.lsu_done & ~empty;
  always_comb begin
    valid_d = ~clear & (accept | (valid_q & ~bus.lsu_inst_ready));
    inst_d  = clear ? '0 : accept ? inst_arr[gnt_id] : inst_q;
    last_d  = clear ? ID_W'(NUM_REQ - 1) : accept ? gnt_id : last_q;
    done_d  = pop ? NUM_REQ'(1) << head_id : '0;
    err_d   = ~clear & (err_q | (bus.lsu_done & empty));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      inst_q  <= '0;
      last_q  <= ID_W'(NUM_REQ - 1);
      done_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      inst_q  <= inst_d;
      last_q  <= last_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
  dca_grant_order_fifo #(.DEPTH(ORDER_DEPTH), .W(ID_W)) u_order (
    .clk     (clk),
    .rst     (rst),
    .clear_i (clear),
    .push_i  (accept),
    .pop_i   (pop),
    .data_i  (gnt_id),
    .data_o  (head_id),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );
  assign bus.req_ready      = accept ? NUM_REQ'(1) << gnt_id : '0;
  assign bus.req_done       = done_q;
  assign bus.lsu_inst_valid = valid_q;
  assign bus.lsu_inst       = inst_q;
  assign busy               = valid_q | (count != '0);
  assign err_spurious_done  = err_q;
endmodule

// File: tb/tb_dca_lsu_inst_arbiter.sv
// tb_dca_lsu_inst_arbiter: directed checks of grant order, stalls, ordering FIFO and clear
module tb_dca_lsu_inst_arbiter;
  import dca_lsu_inst_arbiter_pkg::*;
  localparam int W = DCA_LSU_INST_W;
  localparam logic [W-1:0] INST_A = W'(32'hAAAA_0000);
  localparam logic [W-1:0] INST_B = W'(32'hBBBB_1111);
  logic clk, rst, clear, enable, busy, err;
  int n_checks = 0;
  int n_fail = 0;
  dca_lsu_inst_arbiter_if #(.NUM_REQ(2), .BW_INST(W)) bus ();
  dca_lsu_inst_arbiter #(.NUM_REQ(2), .BW_INST(W), .ORDER_DEPTH(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .clear             (clear),
    .enable            (enable),
    .bus               (bus),
    .busy              (busy),
    .err_spurious_done (err)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    rst = 1'b1; clear = 1'b0; enable = 1'b1;
    bus.req_valid = 2'b00; bus.req_inst = {INST_B, INST_A};
    bus.lsu_inst_ready = 1'b1; bus.lsu_done = 1'b0;
    @(negedge clk);
    check("rst_ready", bus.req_ready, 0);
    check("rst_valid", bus.lsu_inst_valid, 0);
    check("rst_inst", bus.lsu_inst, 0);
    check("rst_done", bus.req_done, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    rst = 1'b0;
    // alternating grants with everything valid
    bus.req_valid = 2'b11; #1;
    check("rr_g0", bus.req_ready, 2'b01);
    step;
    check("rr_v0", bus.lsu_inst_valid, 1);
    check("rr_i0", bus.lsu_inst, INST_A);
    check("rr_g1", bus.req_ready, 2'b10);
    step;
    check("rr_i1", bus.lsu_inst, INST_B);
    bus.req_valid = 2'b00; #1;
    check("rr_idle", bus.req_ready, 2'b00);
    step;
    check("drop_v", bus.lsu_inst_valid, 0);
    check("hold_i", bus.lsu_inst, INST_B);
    check("busy_out", busy, 1);
    bus.lsu_done = 1'b1;
    step;
    check("done_a", bus.req_done, 2'b01);
    step;
    check("done_b", bus.req_done, 2'b10);
    bus.lsu_done = 1'b0;
    step;
    check("done_c", bus.req_done, 2'b00);
    check("busy_idle", busy, 0);
    check("err_clean", err, 0);
    // grants 1,0,1 and their completions in order
    bus.req_valid = 2'b10; #1;
    check("o_g1", bus.req_ready, 2'b10);
    step;
    bus.req_valid = 2'b11; #1;
    check("o_g0", bus.req_ready, 2'b01);
    step;
    check("o_g1b", bus.req_ready, 2'b10);
    step;
    bus.req_valid = 2'b00;
    check("o_inst", bus.lsu_inst, INST_B);
    bus.lsu_done = 1'b1;
    step;
    check("o_d1", bus.req_done, 2'b10);
    step;
    check("o_d0", bus.req_done, 2'b01);
    step;
    check("o_d1b", bus.req_done, 2'b10);
    bus.lsu_done = 1'b0;
    step;
    check("o_dz", bus.req_done, 2'b00);
    // LSU stall for three cycles
    bus.lsu_inst_ready = 1'b0; bus.req_valid = 2'b11; #1;
    check("st_g0", bus.req_ready, 2'b01);
    for (int i = 0; i < 3; i++) begin
      step;
      check("st_inst", bus.lsu_inst, INST_A);
      check("st_valid", bus.lsu_inst_valid, 1);
      check("st_noready", bus.req_ready, 2'b00);
    end
    bus.lsu_inst_ready = 1'b1; #1;
    check("st_resume", bus.req_ready, 2'b10);
    step;
    check("st_i1", bus.lsu_inst, INST_B);
    bus.req_valid = 2'b00;
    step;
    bus.lsu_done = 1'b1;
    step;
    check("st_d0", bus.req_done, 2'b01);
    step;
    check("st_d1", bus.req_done, 2'b10);
    bus.lsu_done = 1'b0;
    step;
    // fill the ordering FIFO
    bus.req_valid = 2'b11;
    for (int i = 0; i < 4; i++) step;
    check("full_block", bus.req_ready, 2'b00);
    check("full_inst", bus.lsu_inst, INST_B);
    bus.lsu_done = 1'b1; #1;
    check("no_bypass", bus.req_ready, 2'b00);
    step;
    check("full_d0", bus.req_done, 2'b01);
    bus.lsu_done = 1'b0; #1;
    check("unblock", bus.req_ready, 2'b01);
    step;
    check("unb_inst", bus.lsu_inst, INST_A);
    // clear with work outstanding and a loaded stage
    bus.req_valid = 2'b00; clear = 1'b1;
    step;
    clear = 1'b0;
    check("clr_busy", busy, 0);
    check("clr_valid", bus.lsu_inst_valid, 0);
    check("clr_inst", bus.lsu_inst, 0);
    check("clr_done", bus.req_done, 2'b00);
    // completion with nothing outstanding
    bus.lsu_done = 1'b1;
    step;
    bus.lsu_done = 1'b0;
    check("sp_err", err, 1);
    check("sp_done", bus.req_done, 2'b00);
    step;
    check("sp_sticky", err, 1);
    check("sp_done2", bus.req_done, 2'b00);
    bus.req_valid = 2'b11; #1;
    check("clr_prio", bus.req_ready, 2'b01);
    enable = 1'b0; #1;
    check("disable", bus.req_ready, 2'b00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
